// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption, one round per clock on a single state register

// sub_bytes: AES S-box applied to all 16 bytes
module sub_bytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    // S-box as the GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end
endmodule

// shift_rows: row r of the column-major state rotates left by r bytes
module shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end
endmodule

// mix_columns: each column multiplied by the circulant {02,03,01,01}
module mix_columns (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    logic [7:0] a [16];
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    for (genvar i = 0; i < 16; i++) begin : g_in
        assign a[i] = din[127-8*i -: 8];
    end
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(r+4*c) -: 8] = xt(a[4*c+r]) ^ xt(a[4*c+(r+1)%4]) ^ a[4*c+(r+1)%4]
                                              ^ a[4*c+(r+2)%4] ^ a[4*c+(r+3)%4];
        end
    end
endmodule

module aes_round_sequencer #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, KEY0, ROUND, FINAL, DONE} fsm_t;
    localparam logic [3:0] NR_L = 4'(NR);
    fsm_t         fsm_q, fsm_d;
    logic [127:0] temp_q, temp_d, blk_q, blk_d;
    logic [127:0] sb_out, sr_out, mc_out;
    logic [3:0]   cnt_q, cnt_d, rk_idx_q, rk_idx_d;
    logic         in_ready_q, in_ready_d, rk_req_q, rk_req_d;
    logic         out_valid_q, out_valid_d, busy_q, busy_d;

    sub_bytes   u_sb (.din(blk_q),  .dout(sb_out));
    shift_rows  u_sr (.din(sb_out), .dout(sr_out));
    mix_columns u_mc (.din(sr_out), .dout(mc_out));

    // next state; the counter always equals the key index wanted in KEY0/ROUND/FINAL
    always_comb begin
        fsm_d  = fsm_q;
        temp_d = temp_q;
        blk_d  = blk_q;
        cnt_d  = cnt_q;
        case (fsm_q)
            IDLE: if (in_valid) begin
                temp_d = data_in;
                cnt_d  = 4'd0;
                fsm_d  = KEY0;
            end
            KEY0: if (rk_valid) begin
                blk_d = temp_q ^ rk;
                cnt_d = 4'd1;
                fsm_d = (NR > 1) ? ROUND : FINAL;
            end
            ROUND: if (rk_valid) begin
                blk_d = mc_out ^ rk;
                cnt_d = cnt_q + 4'd1;
                fsm_d = (cnt_q == NR_L - 4'd1) ? FINAL : ROUND;
            end
            FINAL: if (rk_valid) begin
                blk_d = sr_out ^ rk;
                fsm_d = DONE;
            end
            DONE: fsm_d = out_ready ? IDLE : DONE;
            default: fsm_d = IDLE;
        endcase
        in_ready_d  = fsm_d == IDLE;
        rk_req_d    = fsm_d == KEY0 || fsm_d == ROUND || fsm_d == FINAL;
        rk_idx_d    = rk_req_d ? cnt_d : 4'd0;
        out_valid_d = fsm_d == DONE;
        busy_d      = fsm_d != IDLE;
    end

    // state register and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            temp_q      <= '0;
            blk_q       <= '0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            rk_req_q    <= 1'b0;
            rk_idx_q    <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            temp_q      <= temp_d;
            blk_q       <= blk_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            rk_req_q    <= rk_req_d;
            rk_idx_q    <= rk_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign rk_req    = rk_req_q;
    assign rk_idx    = rk_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign data_out  = blk_q;
endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption controller. It accepts one 128-bit block over a valid/ready handshake and applies the initial AddRoundKey, then NR rounds, one round per cycle on a single state register. It instantiates the combinational sub_bytes, shift_rows and mix_columns blocks (128-bit in/out) and fetches round keys from the key-schedule unit through a request/valid handshake. It sits between the SD data buffer and the output FIFO.

Parameters:
NR, 10, number of full rounds; the final round omits mix_columns. Legal range 1..14.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
in_valid  input  1  data_in holds a block to encrypt
in_ready  output  1  sequencer can accept a block
data_in  input  128  plaintext block
rk_req  output  1  round key requested
rk_idx  output  4  index of requested round key, 0..NR
rk_valid  input  1  rk is valid for rk_idx this cycle
rk  input  128  round key
out_valid  output  1  data_out holds a finished ciphertext
out_ready  input  1  consumer accepts data_out
data_out  output  128  ciphertext, equal to the state register
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, state register=0, round counter=0. Outputs: in_ready=1, rk_req=0, rk_idx=0, out_valid=0, data_out=0, busy=0.
- States: IDLE, KEY0, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid at a clock edge, latch data_in into the temp register, set counter=0, go to KEY0. data_in is sampled only in this cycle.
- KEY0: rk_req=1, rk_idx=0. On rk_valid: state <= temp ^ rk, counter=1. Go to ROUND if NR>1, otherwise FINAL.
- ROUND: rk_req=1, rk_idx=counter. On rk_valid: state <= mix_columns(shift_rows(sub_bytes(state))) ^ rk, counter++. When counter==NR-1 at the edge, go to FINAL.
- FINAL: rk_req=1, rk_idx=NR. On rk_valid: state <= shift_rows(sub_bytes(state)) ^ rk, go to DONE.
- If rk_valid=0, the sequencer stalls: state, counter and rk_idx hold, and rk_req stays 1. rk_valid is ignored whenever rk_req=0.
- DONE: out_valid=1, data_out stable. On out_ready, go to IDLE. in_ready is asserted in the next cycle, so there is no same-cycle pass-through.
- in_ready=1 only in IDLE. in_valid is ignored in every other state.
- out_ready is ignored outside DONE.
- Latency with rk_valid tied high: a block accepted at edge 0 gives out_valid=1 after edge NR+1 (11 cycles for NR=10). Each rk_valid=0 cycle adds 1 cycle.
- Throughput: one block per NR+3 cycles minimum.
- Reset mid-operation: immediate return to reset values. The partial block is discarded and no out_valid is produced.
- data_out always equals the state register. Only the DONE-qualified value is meaningful.
- The round counter is 4 bits wide, counts from 0 to NR, and never wraps.

Test Plan:
- Zero vector: data_in=0, every rk=0, rk_valid=1, out_ready=1, NR=10 -> out_valid=1 exactly 11 cycles after acceptance; data_out=0x36 repeated in all 16 bytes. Successive per-round uniform state bytes are 00,63,fb,0f,76,38,07,c5,a6,24,36; check the internal state each round.
- Key stall: same stimulus, with rk_valid low for 3 cycles at rk_idx=4 -> rk_idx holds at 4 and rk_req stays high; result is still 0x36…36 at 14 cycles.
- Random vectors: 200 random plaintexts and key sets, compared against a golden model built from the same sub-block functions. Also checks rk_idx=0..10 in order, each index requested exactly once per accepted rk_valid.
- Output backpressure: out_ready=0 for 5 cycles -> out_valid and data_out hold, in_ready=0 and in_valid is ignored. After out_ready, in_ready=1 on the next cycle.
- Reset mid-operation: rst pulsed at ROUND with rk_idx=5 -> all outputs return to reset values asynchronously. A new block is then accepted and completes correctly.
- NR=1 build: zero vector -> FINAL directly after KEY0; data_out=0x63…63 after 2 cycles.
